// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared CPU datapath constants: register op encodings and width.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int DATA_WIDTH = 18;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/d_flip_flop.sv
// ============================================================================
// Module : d_flip_flop
// Brief  : Single-bit D flip-flop with synchronous active-high reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module d_flip_flop #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else begin
      q <= d;
    end
  end

endmodule : d_flip_flop

`default_nettype wire

// File: rtl/univ_reg.sv
// ============================================================================
// Module : univ_reg
// Brief  : N-bit universal register (load/inc/dec/shift/clear) with carry
//          and zero flags, stored in per-bit d_flip_flop instances.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module univ_reg
  import cpu_pkg::*;
#(
  parameter int         N           = DATA_WIDTH,
  parameter logic [N-1:0] RESET_VALUE = {N{1'b0}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [2:0]   op,
  input  logic [N-1:0] data_in,
  input  logic         serial_in,
  output logic [N-1:0] data_out,
  output logic         carry_out,
  output logic         zero
);

  localparam logic [N:0]   c_one_wide = {{N{1'b0}}, 1'b1};
  localparam logic [N-1:0] c_one      = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] r_q;
  logic         r_carry;
  logic [N-1:0] w_d_next;
  logic         w_carry_next;
  logic [N:0]   w_sum;

  assign w_sum = {1'b0, r_q} + c_one_wide;

  // Disabled or HOLD feeds the flops their own value; reset lives in the flops.
  always_comb begin
    w_d_next     = r_q;
    w_carry_next = r_carry;
    if (enable) begin
      case (op)
        OP_LOAD: begin
          w_d_next     = data_in;
          w_carry_next = 1'b0;
        end
        OP_INC: begin
          w_d_next     = w_sum[N-1:0];
          w_carry_next = w_sum[N];
        end
        OP_DEC: begin
          w_d_next     = r_q - c_one;
          w_carry_next = (r_q == {N{1'b0}});
        end
        OP_SHL: begin
          w_d_next     = {r_q[N-2:0], serial_in};
          w_carry_next = r_q[N-1];
        end
        OP_SHR: begin
          w_d_next     = {serial_in, r_q[N-1:1]};
          w_carry_next = r_q[0];
        end
        OP_ASR: begin
          w_d_next     = {r_q[N-1], r_q[N-1:1]};
          w_carry_next = r_q[0];
        end
        OP_CLR: begin
          w_d_next     = {N{1'b0}};
          w_carry_next = 1'b0;
        end
        default: begin
          w_d_next     = r_q;
          w_carry_next = r_carry;
        end
      endcase
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_bit
    d_flip_flop #(
      .RESET_VALUE (RESET_VALUE[i])
    ) u_ff (
      .clk   (clk),
      .reset (reset),
      .d     (w_d_next[i]),
      .q     (r_q[i])
    );
  end

  d_flip_flop #(
    .RESET_VALUE (1'b0)
  ) u_carry_ff (
    .clk   (clk),
    .reset (reset),
    .d     (w_carry_next),
    .q     (r_carry)
  );

  assign data_out  = r_q;
  assign carry_out = r_carry;
  assign zero      = (r_q == {N{1'b0}});

endmodule : univ_reg

`default_nettype wire
